mem_access_unit: RTL

- MEM-stage data-memory access controller; sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Converts EX/MEM control (MemRead, MemWrite, BHW, DataMemExtendSign) into a req/ack data-memory bus transaction: store lane alignment, load extraction and extension, pipeline stall while waiting, timeout on a missing ack.
- Byte ordering is big-endian: addr[1:0]=0 selects bits 31:24.

---
 rtl/mem_access_unit.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage data-memory access controller. It sits right after the EX/MEM
// pipeline register and feeds the MEM/WB register. One load or store from
// EX/MEM becomes a single req/ack transaction on the data-memory bus:
//   - store data is aligned to its byte lanes and gets byte enables;
//   - load data is taken from its lane and sign- or zero-extended;
//   - upstream stages are stalled while the access is in flight;
//   - a bus that never acks is abandoned after TIMEOUT_CYCLES request cycles.
// Byte order is big-endian: address offset 0 is bits 31:24 of the bus word.
//
// Optional feature (compile-time macro):
//   MEM_MISALIGN_TRAP_EN  - when defined, a misaligned halfword/word access
//                           makes no bus request and pulses access_err.
//                           When undefined, the low address bits are dropped
//                           and the access goes ahead truncated-aligned.
//
// Parameters:
//   TIMEOUT_CYCLES  request cycles without mem_ack before abort (2..255)
//   CNT_W           width of the wait counter
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset
//   MemRead_in           load request from EX/MEM
//   MemWrite_in          store request from EX/MEM
//   BHW_in[1:0]          access size: 00 word, 01 half, 10 byte, 11 illegal
//   DataMemExtendSign_in 1 = sign-extend sub-word loads, 0 = zero-extend
//   ALUResult_in[31:0]   effective address
//   ReadData2_in[31:0]   store data, right-justified
//   mem_req              bus request, held until ack or abort
//   mem_we               1 = write
//   mem_addr[31:0]       word-aligned bus address
//   mem_be[3:0]          byte enables, bit 3 = bits 31:24
//   mem_wdata[31:0]      lane-aligned store data
//   mem_rdata[31:0]      read data, valid with mem_ack
//   mem_ack              one-cycle completion strobe
//   stall                freezes upstream stages and EX/MEM
//   LoadData_out[31:0]   extended load result, valid in DONE and held
//   access_done          one-cycle pulse on successful completion
//   access_err           one-cycle pulse on illegal, misaligned or timeout
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  BHW_in,
    input  logic        DataMemExtendSign_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] ReadData2_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] LoadData_out,
    output logic        access_done,
    output logic        access_err
);

    localparam logic [1:0] BHW_WORD = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_BYTE = 2'b10;
    localparam logic [1:0] BHW_ILL  = 2'b11;

    // The abort fires in the request cycle whose count equals this value,
    // so mem_req is held for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t stateReg;
    state_t stateNext;

    // Attributes of the access in flight, latched when it leaves IDLE.
    logic [1:0]       bhwReg;
    logic             signReg;
    logic [1:0]       laneReg;
    logic             isLoadReg;
    logic [CNT_W-1:0] cntReg;

    logic stallComb;

    // -------------------------------------------------------------------------
    // Request decode in IDLE
    // -------------------------------------------------------------------------
    logic oneReq;
    logic anyReq;
    logic illegalReq;
    logic trapReq;
    logic startAcc;
    logic startErr;

    assign oneReq     = MemRead_in ^ MemWrite_in;
    assign anyReq     = MemRead_in | MemWrite_in;
    // BHW=11 only matters when a memory access is actually requested;
    // non-memory instructions may carry any value in that field.
    assign illegalReq = (MemRead_in & MemWrite_in) | (anyReq & (BHW_in == BHW_ILL));

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((BHW_in == BHW_HALF) & ALUResult_in[0]) |
                        ((BHW_in == BHW_WORD) & (ALUResult_in[1:0] != 2'b00));
    assign trapReq    = oneReq & (BHW_in != BHW_ILL) & misaligned;
`else
    // Misaligned accesses proceed with the low address bits ignored.
    assign trapReq    = 1'b0;
`endif

    assign startAcc = oneReq & (BHW_in != BHW_ILL) & ~trapReq;
    assign startErr = illegalReq | trapReq;

    // -------------------------------------------------------------------------
    // Store lane alignment
    // Lane gi carries address offset gi and maps to mem_be[3-gi] and
    // bus bits [31-8*gi -: 8].
    // -------------------------------------------------------------------------
    logic [3:0]  beNext;
    logic [31:0] wdataNext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_storeLane
            logic halfHit;
            logic byteHit;
            // Halfword lanes 0/1 are the upper half (addr[1]=0).
            assign halfHit = (ALUResult_in[1] == 1'(gi / 2));
            assign byteHit = (ALUResult_in[1:0] == 2'(gi));
            assign beNext[3-gi] = (BHW_in == BHW_WORD) |
                                  ((BHW_in == BHW_HALF) & halfHit) |
                                  ((BHW_in == BHW_BYTE) & byteHit);
        end
    endgenerate

    // Sub-word store data is replicated into every lane; the byte enables
    // pick which copy memory actually writes.
    always_comb begin
        wdataNext = ReadData2_in;
        case (BHW_in)
            BHW_HALF: wdataNext = {2{ReadData2_in[15:0]}};
            BHW_BYTE: wdataNext = {4{ReadData2_in[7:0]}};
            default:  wdataNext = ReadData2_in;
        endcase
    end

    // -------------------------------------------------------------------------
    // Load extraction and extension
    // -------------------------------------------------------------------------
    logic [7:0]  laneByte [4];
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadExt;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_loadLane
            assign laneByte[gi] = mem_rdata[31-8*gi -: 8];
        end
    endgenerate

    assign byteSel = laneByte[laneReg];
    assign halfSel = laneReg[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    always_comb begin
        loadExt = mem_rdata;
        case (bhwReg)
            BHW_HALF: loadExt = {{16{signReg & halfSel[15]}}, halfSel};
            BHW_BYTE: loadExt = {{24{signReg & byteSel[7]}}, byteSel};
            default:  loadExt = mem_rdata;   // word loads ignore the sign flag
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: next state and stall
    // -------------------------------------------------------------------------
    logic timeoutHit;
    assign timeoutHit = (cntReg == CNT_LAST);

    always_comb begin
        stateNext = stateReg;
        stallComb = 1'b0;
        case (stateReg)
            IDLE: begin
                // Any memory instruction holds EX/MEM until DONE, including
                // the error path, so it is consumed exactly once.
                if (startAcc) begin
                    stallComb = 1'b1;
                    stateNext = REQ;
                end else if (startErr) begin
                    stallComb = 1'b1;
                    stateNext = DONE;
                end
            end
            REQ: begin
                stallComb = 1'b1;
                // Ack is tested first so a coincident timeout still completes.
                if (mem_ack || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Nothing upstream stays frozen while reset is held.
    assign stall = stallComb & rst;

    // -------------------------------------------------------------------------
    // State, bus and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg     <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            LoadData_out <= 32'd0;
            access_done  <= 1'b0;
            access_err   <= 1'b0;
            cntReg       <= '0;
            bhwReg       <= BHW_WORD;
            signReg      <= 1'b0;
            laneReg      <= 2'b00;
            isLoadReg    <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            access_done <= 1'b0;
            access_err  <= 1'b0;
            case (stateReg)
                IDLE: begin
                    cntReg <= '0;
                    if (startAcc) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_in;
                        mem_addr  <= {ALUResult_in[31:2], 2'b00};
                        mem_be    <= beNext;
                        mem_wdata <= wdataNext;
                        bhwReg    <= BHW_in;
                        signReg   <= DataMemExtendSign_in;
                        laneReg   <= ALUResult_in[1:0];
                        isLoadReg <= MemRead_in;
                    end else if (startErr) begin
                        access_err <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        access_done <= 1'b1;
                        cntReg      <= '0;
                        if (isLoadReg) begin
                            LoadData_out <= loadExt;
                        end
                    end else if (timeoutHit) begin
                        mem_req    <= 1'b0;
                        access_err <= 1'b1;
                        cntReg     <= '0;
                    end else begin
                        cntReg <= cntReg + 1'b1;
                    end
                end
                default: begin
                    cntReg <= '0;
                end
            endcase
        end
    end

endmodule
